// File: rtl/warp_issue_scheduler_pkg.sv
// Shared types and sizing for the warp issue scheduler: warp/thread widths,
// instruction word type and the per-slot state encoding.
package warp_issue_scheduler_pkg;

  localparam int NUM_WARPS  = 4;
  localparam int INTU_CORES = 4;
  localparam int THREADS    = INTU_CORES;
  localparam int WID_W      = 6;
  localparam int WARP_W     = $clog2(NUM_WARPS);

  typedef logic [31:0]         instruction_t;
  typedef logic [THREADS-1:0]  tmask_t;
  typedef logic [WARP_W-1:0]   warp_idx_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_READY   = 2'd1,
    SLOT_PARTIAL = 2'd2
  } slot_state_e;

  // IDP expects a wider WarpID than the slot index; pad with zeros.
  function automatic logic [WID_W-1:0] to_warp_id(input warp_idx_t idx);
    return {{(WID_W-WARP_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Fetch-side push channel, per-warp/lane status and IDP-side issue outputs
// of the warp issue scheduler, bundled as one interface.
interface warp_issue_scheduler_if;
  import warp_issue_scheduler_pkg::*;

  logic                  push_valid_i;
  logic                  push_ready_o;
  warp_idx_t             push_warp_i;
  instruction_t          push_inst_i;
  tmask_t                push_mask_i;
  logic [NUM_WARPS-1:0]  warp_stall_i;
  tmask_t                lane_free_i;
  logic                  flush_i;
  instruction_t          inst_o;
  logic [WID_W-1:0]      warp_id_o;
  tmask_t                thread_mask_o;
  logic                  issue_valid_o;
  logic [15:0]           issue_cnt_o;

  modport master (
    output push_valid_i, push_warp_i, push_inst_i, push_mask_i,
           warp_stall_i, lane_free_i, flush_i,
    input  push_ready_o, inst_o, warp_id_o, thread_mask_o,
           issue_valid_o, issue_cnt_o
  );

  modport slave (
    input  push_valid_i, push_warp_i, push_inst_i, push_mask_i,
           warp_stall_i, lane_free_i, flush_i,
    output push_ready_o, inst_o, warp_id_o, thread_mask_o,
           issue_valid_o, issue_cnt_o
  );

endinterface

// File: rtl/warp_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after i_ptr, wrapping
// modulo N (N a power of two), and returns it as one-hot and as an index.
module warp_issue_scheduler_rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [PTR_W-1:0] cand;
      cand = i_ptr + k[PTR_W-1:0];
      if (!o_valid && i_req[cand]) begin
        o_valid       = 1'b1;
        o_idx         = cand;
        o_grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: per-warp instruction slots, PARTIAL-first then
// round-robin selection, and registered issue of lane-free threads to IDP.
module warp_issue_scheduler
  import warp_issue_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  warp_issue_scheduler_if.slave  bus
);

  slot_state_e          r_state     [NUM_WARPS];
  slot_state_e          w_state_nxt [NUM_WARPS];
  tmask_t               r_pend      [NUM_WARPS];
  tmask_t               w_pend_nxt  [NUM_WARPS];
  instruction_t         r_inst      [NUM_WARPS];
  warp_idx_t            r_rr_ptr;
  warp_idx_t            w_rr_ptr_nxt;

  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_part_req;
  logic [NUM_WARPS-1:0] w_ready_req;
  logic [NUM_WARPS-1:0] w_part_onehot;
  logic [NUM_WARPS-1:0] w_rr_grant;
  logic [NUM_WARPS-1:0] w_sel_onehot;
  warp_idx_t            w_part_idx;
  warp_idx_t            w_rr_idx;
  warp_idx_t            w_sel_idx;
  logic                 w_part_valid;
  logic                 w_rr_valid;
  logic                 w_sel_valid;
  tmask_t               w_issue_mask;
  tmask_t               w_left_mask;
  logic                 w_push_fire;

  instruction_t         r_inst_o;
  logic [WID_W-1:0]     r_warp_id;
  tmask_t               r_mask;
  logic                 r_valid;
  logic [15:0]          r_cnt;

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see the
    // values computed earlier in the same evaluation.
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_elig[w]      = (r_state[w] != SLOT_EMPTY) && !bus.warp_stall_i[w] &&
                       |(r_pend[w] & bus.lane_free_i);
      w_part_req[w]  = w_elig[w] && (r_state[w] == SLOT_PARTIAL);
      w_ready_req[w] = w_elig[w] && (r_state[w] == SLOT_READY);
    end
  end

  // A half-issued instruction finishes before any fresh one starts.
  always_comb begin
    w_part_onehot = '0;
    w_part_idx    = '0;
    w_part_valid  = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (w_part_req[w] && !w_part_valid) begin
        w_part_valid     = 1'b1;
        w_part_idx       = warp_idx_t'(w);
        w_part_onehot[w] = 1'b1;
      end
    end
  end

  warp_issue_scheduler_rr_arbiter #(.N(NUM_WARPS)) u_rr_arbiter (
    .i_req   (w_ready_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  assign w_sel_valid  = w_part_valid | w_rr_valid;
  assign w_sel_idx    = w_part_valid ? w_part_idx    : w_rr_idx;
  assign w_sel_onehot = w_part_valid ? w_part_onehot : w_rr_grant;
  assign w_issue_mask = r_pend[w_sel_idx] & bus.lane_free_i;
  assign w_left_mask  = r_pend[w_sel_idx] & ~bus.lane_free_i;

  // Ready looks at the current state, so a slot popped this cycle refills next cycle.
  assign bus.push_ready_o = (r_state[bus.push_warp_i] == SLOT_EMPTY) && !bus.flush_i;
  assign w_push_fire      = bus.push_valid_i && bus.push_ready_o && |bus.push_mask_i;

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_state_nxt[w] = r_state[w];
      w_pend_nxt[w]  = r_pend[w];
    end
    if (bus.flush_i) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        w_state_nxt[w] = SLOT_EMPTY;
        w_pend_nxt[w]  = '0;
      end
      w_rr_ptr_nxt = '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_sel_valid && w_sel_onehot[w]) begin
          w_pend_nxt[w]  = r_pend[w] & ~bus.lane_free_i;
          w_state_nxt[w] = (w_pend_nxt[w] == '0) ? SLOT_EMPTY : SLOT_PARTIAL;
        end
      end
      if (w_sel_valid && (w_left_mask == '0)) begin
        w_rr_ptr_nxt = w_sel_idx + warp_idx_t'(1);
      end
      // The pushed slot is EMPTY, so it can never be the one being issued.
      if (w_push_fire) begin
        w_state_nxt[bus.push_warp_i] = SLOT_READY;
        w_pend_nxt[bus.push_warp_i]  = bus.push_mask_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_state[w] <= SLOT_EMPTY;
        r_pend[w]  <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_state[w] <= w_state_nxt[w];
        r_pend[w]  <= w_pend_nxt[w];
      end
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // NOTE: the instruction store has no reset; an EMPTY slot's word is never
  // read, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push_fire) begin
      r_inst[bus.push_warp_i] <= bus.push_inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_o  <= '0;
      r_warp_id <= '0;
      r_mask    <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
    end else if (bus.flush_i) begin
      r_mask  <= '0;
      r_valid <= 1'b0;
    end else if (w_sel_valid) begin
      r_inst_o  <= r_inst[w_sel_idx];
      r_warp_id <= to_warp_id(w_sel_idx);
      r_mask    <= w_issue_mask;
      r_valid   <= 1'b1;
      r_cnt     <= r_cnt + 16'd1;
    end else begin
      r_mask  <= '0;
      r_valid <= 1'b0;
    end
  end

  assign bus.inst_o        = r_inst_o;
  assign bus.warp_id_o     = r_warp_id;
  assign bus.thread_mask_o = r_mask;
  assign bus.issue_valid_o = r_valid;
  assign bus.issue_cnt_o   = r_cnt;

endmodule
